// File: rtl/mem_adapter_pkg.sv
// Shared types and helpers for the memory request adapter.
package mem_adapter_pkg;

  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;
  // Byte-offset bits within one beat; any of them set means misaligned.
  localparam int OFF_W      = $clog2(REQ_DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [REQ_ADDR_W-1:0] addr);
    return (addr[OFF_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/mem_req_adapter_fifo.sv
// Small in-order FIFO with a combinational head so the consumer can
// latch the oldest entry in the same cycle it pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = store_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates all reads.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_adapter.sv
// Buffers single-beat requests and sequences them onto a simple memory
// port, returning one in-order response per request.
module mem_req_adapter
  import mem_adapter_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  req_t              push_req, head_req, cur_q, cur_d;
  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              fifo_full, fifo_empty, fifo_pop;

  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;

  sync_fifo #(
    .WIDTH($bits(req_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (req_valid),
    .pop_i  (fifo_pop),
    .wdata_i(push_req),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head_req)
  );

  // Next-state and output decode; memory strobes come straight from state
  // so a reset removes them in the very next cycle.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    mem_en     = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = head_req;
          rdata_d  = '0;
          if (is_aligned(head_req.addr)) begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            // Misaligned: answer with an error and never touch memory.
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        mem_addr = cur_q.addr;
        if (cur_q.write) begin
          mem_wen   = 1'b1;
          mem_wdata = cur_q.wdata;
          state_d   = RESP;
        end else begin
          mem_en = 1'b1;
          if (RD_LAT == 0) begin
            rdata_d = mem_rdata;
            state_d = RESP;
          end else begin
            wait_d  = 4'(RD_LAT - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_en   = 1'b1;
        mem_addr = cur_q.addr;
        if (wait_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_write = (state_q == RESP) && cur_q.write;
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP) ? rdata_q : '0;
  end

  // State, current request and response payload registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_adapter.sv
// Directed bench for mem_req_adapter: one instance with RD_LAT=1, one with RD_LAT=0.
module tb_mem_req_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  // Instance A (RD_LAT = 1)
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_write, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_en, mem_wen;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  // Instance B (RD_LAT = 0)
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [63:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_write, b_resp_err;
  logic [63:0] b_resp_rdata;
  logic        b_mem_en, b_mem_wen;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];

  int n_pass  = 0;
  int n_check = 0;

  logic        q_write [8];
  logic [63:0] q_addr  [8];
  logic [63:0] q_wdata [8];
  logic [63:0] exp_rdata [8];
  logic        exp_err [8];

  always #5 clk = ~clk;

  mem_req_adapter #(.ADDR_W(64), .DATA_W(64), .DEPTH(4), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_req_adapter #(.ADDR_W(64), .DATA_W(64), .DEPTH(4), .RD_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
    .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
    .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models: combinational read, write on the clock edge.
  always_comb mem_rdata   = mem_en   ? mem_a[mem_addr[6:3]]   : 64'd0;
  always_comb b_mem_rdata = b_mem_en ? mem_b[b_mem_addr[6:3]] : 64'd0;
  always @(posedge clk) if (mem_wen)   mem_a[mem_addr[6:3]]   <= mem_wdata;
  always @(posedge clk) if (b_mem_wen) mem_b[b_mem_addr[6:3]] <= b_mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_q(input int i, input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] er, input logic ee);
    q_write[i] = w; q_addr[i] = a; q_wdata[i] = d; exp_rdata[i] = er; exp_err[i] = ee;
  endtask

  task automatic drive_req(input int i);
    req_valid = 1'b1; req_write = q_write[i]; req_addr = q_addr[i]; req_wdata = q_wdata[i];
  endtask

  // Pushes q[push_start..n-1] and checks responses resp_start..n-1 in order.
  task automatic run_batch(input int n, input int push_start, input int resp_start);
    int  pi  = push_start;
    int  ri  = resp_start;
    int  cyc = 0;
    logic pushed;
    while ((ri < n) && (cyc < 300)) begin
      if (pi < n) drive_req(pi);
      else req_valid = 1'b0;
      pushed = (pi < n) && req_ready;
      if (resp_valid && resp_ready) begin
        chk($sformatf("resp%0d_write", ri), {63'd0, resp_write}, {63'd0, q_write[ri]});
        chk($sformatf("resp%0d_rdata", ri), resp_rdata, exp_rdata[ri]);
        chk($sformatf("resp%0d_err", ri), {63'd0, resp_err}, {63'd0, exp_err[ri]});
        $display("resp %0d addr=0x%0h rdata=0x%0h err=%0b", ri, q_addr[ri], resp_rdata, resp_err);
        ri++;
      end
      tick();
      if (pushed) pi++;
      cyc++;
    end
    req_valid = 1'b0;
    chk("batch_resp_count", 64'(ri), 64'(n));
  endtask

  initial begin
    int seen;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    tick();

    // Write 0xDEA to 0x8: ISSUE at T+2, response at T+3
    set_q(0, 1'b1, 64'h8, 64'hDEA, 64'd0, 1'b0);
    drive_req(0);
    tick(); req_valid = 1'b0;
    chk("wr_t1_mem_wen", {63'd0, mem_wen}, 64'd0);
    tick();
    chk("wr_t2_mem_wen", {63'd0, mem_wen}, 64'd1);
    chk("wr_t2_mem_addr", mem_addr, 64'h8);
    chk("wr_t2_mem_wdata", mem_wdata, 64'hDEA);
    chk("wr_t2_resp_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("wr_t3_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("wr_t3_resp_write", {63'd0, resp_write}, 64'd1);
    chk("wr_t3_resp_err", {63'd0, resp_err}, 64'd0);
    chk("wr_t3_mem_wen", {63'd0, mem_wen}, 64'd0);
    $display("write addr=0x8 data=0xdea ack");
    tick();

    // Read back 0x8 with RD_LAT=1: mem_en for 2 cycles, response at T+4
    set_q(0, 1'b0, 64'h8, 64'd0, 64'hDEA, 1'b0);
    drive_req(0);
    tick(); req_valid = 1'b0;
    chk("rd_t1_mem_en", {63'd0, mem_en}, 64'd0);
    tick();
    chk("rd_t2_mem_en", {63'd0, mem_en}, 64'd1);
    chk("rd_t2_mem_addr", mem_addr, 64'h8);
    tick();
    chk("rd_t3_mem_en", {63'd0, mem_en}, 64'd1);
    chk("rd_t3_resp_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("rd_t4_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("rd_t4_resp_rdata", resp_rdata, 64'hDEA);
    chk("rd_t4_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rd_t4_mem_en", {63'd0, mem_en}, 64'd0);
    $display("read addr=0x8 rdata=0x%0h", resp_rdata);
    tick();

    // Misaligned read: straight to an error response, no memory access
    set_q(0, 1'b0, 64'h13, 64'd0, 64'd0, 1'b1);
    drive_req(0);
    tick(); req_valid = 1'b0;
    chk("mis_t1_mem_en", {63'd0, mem_en}, 64'd0);
    chk("mis_t1_mem_wen", {63'd0, mem_wen}, 64'd0);
    tick();
    chk("mis_t2_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("mis_t2_resp_err", {63'd0, resp_err}, 64'd1);
    chk("mis_t2_resp_rdata", resp_rdata, 64'd0);
    chk("mis_t2_mem_en", {63'd0, mem_en}, 64'd0);
    $display("read addr=0x13 err=%0b", resp_err);
    tick();

    // Backpressure: 6 writes with resp_ready low; 5 fit (4 queued + 1 in RESP)
    for (int i = 0; i < 6; i++) set_q(i, 1'b1, 64'(8 * i), 64'(256 + i), 64'd0, 1'b0);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(i);
      chk($sformatf("fill%0d_req_ready", i), {63'd0, req_ready}, 64'd1);
      tick();
    end
    drive_req(5);
    chk("full_req_ready", {63'd0, req_ready}, 64'd0);
    chk("full_resp_valid", {63'd0, resp_valid}, 64'd1);
    tick(); tick();
    chk("full_hold_req_ready", {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    run_batch(6, 5, 0);
    for (int i = 0; i < 6; i++) set_q(i, 1'b0, 64'(8 * i), 64'd0, 64'(256 + i), 1'b0);
    run_batch(6, 0, 0);

    // Simultaneous push and pop with DEPTH-1 entries queued
    for (int i = 0; i < 6; i++) set_q(i, 1'b1, 64'(48 + 8 * i), 64'(512 + i), 64'd0, 1'b0);
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(i);
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    drive_req(4);
    chk("pp_pre_req_ready", {63'd0, req_ready}, 64'd1);
    tick();
    chk("pp_post_req_ready", {63'd0, req_ready}, 64'd1);
    drive_req(5);
    tick();
    req_valid = 1'b0;
    chk("pp_full_req_ready", {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    run_batch(6, 6, 1);
    for (int i = 0; i < 6; i++) set_q(i, 1'b0, 64'(48 + 8 * i), 64'd0, 64'(512 + i), 1'b0);
    run_batch(6, 0, 0);

    // Reset while in WAIT with 2 entries queued
    for (int i = 0; i < 3; i++) set_q(i, 1'b0, 64'(8 * i), 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_req(i);
      tick();
    end
    req_valid = 1'b0;
    chk("prerst_mem_en", {63'd0, mem_en}, 64'd1);
    chk("prerst_resp_valid", {63'd0, resp_valid}, 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("midrst_resp_rdata", resp_rdata, 64'd0);
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid || mem_en || mem_wen) seen++;
      tick();
    end
    chk("postrst_activity", 64'(seen), 64'd0);
    $display("reset in WAIT: post-reset active cycles=%0d", seen);

    // RD_LAT=0 instance: write 0x55 to 0x8, then read it back at T+3
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 64'h8; b_req_wdata = 64'h55;
    tick(); b_req_valid = 1'b0;
    tick(); tick();
    chk("b_wr_t3_resp_valid", {63'd0, b_resp_valid}, 64'd1);
    tick();
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h8; b_req_wdata = 64'd0;
    tick(); b_req_valid = 1'b0;
    chk("b_rd_t1_resp_valid", {63'd0, b_resp_valid}, 64'd0);
    tick();
    chk("b_rd_t2_mem_en", {63'd0, b_mem_en}, 64'd1);
    tick();
    chk("b_rd_t3_resp_valid", {63'd0, b_resp_valid}, 64'd1);
    chk("b_rd_t3_resp_rdata", b_resp_rdata, 64'h55);
    chk("b_rd_t3_mem_en", {63'd0, b_mem_en}, 64'd0);
    $display("rdlat0 read addr=0x8 rdata=0x%0h", b_resp_rdata);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/mem_req_adapter.md
Name: mem_req_adapter

Overview:
- Upstream neighbour of the DPI-backed memory model, which is driven over its en/wen/addr/wdata/rdata port.
- Accepts single-beat read/write requests on a valid/ready channel and buffers them in a small in-order FIFO.
- Sequences each request onto the memory port with a configurable read latency.
- Returns one response per request (read data or write ack, plus error flag) on a valid/ready channel.

Parameters:
- ADDR_W, 64, request/memory address width.
- DATA_W, 64, data width; bytes per beat = DATA_W/8.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- RD_LAT, 1, extra cycles mem_en/mem_addr are held before mem_rdata is sampled; range 0..15.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request FIFO not full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_write  out  1  echo of req_write.
- resp_err  out  1  misaligned address; no memory access done.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- mem_en  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_en/mem_addr.

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low.
- Reset (rst_n=0 at posedge):
  - FIFO emptied, FSM to IDLE, wait counter 0.
  - All outputs 0 except req_ready=1.
  - In-flight request dropped; no response produced.
  - mem_wen deasserts immediately (combinational from state), so no partial write occurs.
- FIFO:
  - Push on req_valid&&req_ready; pop when FSM leaves IDLE.
  - req_ready = !full. Full state must not drop or overwrite an entry.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty → latch head into cur register, pop.
    - Aligned (addr[log2(DATA_W/8)-1:0]==0) → ISSUE.
    - Misaligned → RESP with err=1, rdata=0.
  - ISSUE, one cycle, mem_addr=cur.addr:
    - Write: mem_wen=1, mem_wdata=cur.wdata; the write commits at the ending posedge; → RESP.
    - Read: mem_en=1. If RD_LAT=0, capture mem_rdata at the ending posedge → RESP; else → WAIT with counter=RD_LAT-1.
  - WAIT: mem_en=1, mem_addr held. Counter decrements each cycle; at 0, capture mem_rdata → RESP.
  - RESP: resp_valid=1, payload stable until resp_ready. On handshake → IDLE.
- Outside ISSUE/WAIT: mem_en=mem_wen=0, mem_addr=mem_wdata=0.
- Latency, with request accepted in cycle T, FIFO previously empty, FSM idle:
  - IDLE in T+1; ISSUE in T+2.
  - Write: resp_valid in T+3.
  - Read: resp_valid in T+3+RD_LAT.
- Back-to-back: the next request enters ISSUE no earlier than 2 cycles after the previous resp handshake (RESP→IDLE→ISSUE).
- Ordering: responses strictly in request order; exactly one response per accepted request.
- No combinational path from resp_ready to req_ready, or from req_valid to any output.

Decomposition:
- Package mem_adapter_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - req_t struct {write, addr, wdata}.
  - Constant OFF_W = $clog2(DATA_W/8).
  - Function is_aligned(addr).
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head), instantiated with WIDTH = $bits(req_t).
- FSM and response register stay in mem_req_adapter.

Test Plan:
- Write addr=0x8, wdata=0xDEA, then read addr=0x8, with RD_LAT=1 and resp_ready=1.
  - → write resp in T+3, resp_write=1, err=0.
  - → read resp_rdata=0xDEA, err=0.
  - → mem_wen high for exactly 1 cycle; mem_en high for 2 cycles.
- Read addr=0x13 (misaligned).
  - → resp_err=1, resp_rdata=0, mem_en/mem_wen never asserted.
- resp_ready=0 while pushing 6 writes (DEPTH=4) to 0x0,0x8,…,0x28.
  - → req_ready=0 after FIFO full plus one held in RESP.
  - → release resp_ready; all 6 acks arrive in order.
  - → reads return the written values.
- RD_LAT=0: read addr=0x8 after writing 0x55.
  - → resp_valid in T+3 with 0x55.
- rst_n=0 for 1 cycle while in WAIT with 2 entries queued.
  - → next cycle all outputs 0, req_ready=1, no response ever emitted for the dropped requests.
- Simultaneous push and pop with FIFO holding DEPTH-1 entries.
  - → req_ready stays 1, occupancy unchanged, no entry lost.
